// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default frame
// parameters (100 MHz clock, 115200 baud, 8N1).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_STOP_BITS    = 1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame-level UART transmitter. Takes one parallel word per valid/ready
// handshake and shifts it out LSB-first as start bit, data bits and stop
// bit(s), each held for CLKS_PER_BIT clocks. Drives the select and data
// inputs of the downstream line mux (tx_sel=1 routes tx_bit to the pin,
// tx_sel=0 routes the idle-high level).
//
// Ports:
//   clk       in   single clock, all state on rising edge
//   rst_n     in   synchronous active-low reset
//   tx_valid  in   producer has a word
//   tx_data   in   word to send, sampled only at the handshake
//   tx_ready  out  idle, can accept a word
//   tx_sel    out  frame active (line mux select)
//   tx_bit    out  current serial bit
//   tx_done   out  one-cycle pulse after the last stop bit
//
// state | meaning
// IDLE  | line idle, tx_ready=1, waiting for tx_valid
// START | driving the start bit (0)
// DATA  | driving shreg[0], one data bit per period
// STOP  | driving stop bit(s) (1), STOP_BITS periods
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int STOP_BITS    = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_sel,
  output logic                 tx_bit,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  assign bit_end  = (bit_cnt == CNT_LAST);
  assign tx_ready = (state == IDLE);

  // tx_sel/tx_bit are registered alongside the state transition so the
  // line value changes on the same edge as the state, with no decode glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      tx_sel   <= 1'b0;
      tx_bit   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            bit_cnt  <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            state    <= START;
            tx_sel   <= 1'b1;
            tx_bit   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            idx     <= '0;
            state   <= DATA;
            tx_bit  <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            idx     <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx_bit   <= 1'b1;
            end else begin
              // next bit to appear once the shift lands
              tx_bit <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
              tx_sel   <= 1'b0;
              tx_bit   <= 1'b1;
              tx_done  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_sel <= 1'b0;
          tx_bit <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic       tx_valid, tx_valid2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_ready, tx_sel, tx_bit, tx_done;
  logic       tx_ready2, tx_sel2, tx_bit2, tx_done2;

  int total = 0;
  int bad   = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_sel(tx_sel), .tx_bit(tx_bit), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx_sel(tx_sel2), .tx_bit(tx_bit2), .tx_done(tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in frame cycle c (1-based), 4 clocks per bit.
  function automatic logic exp_bit(input logic [7:0] d, input int c);
    int pos;
    pos = (c - 1) / 4;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    return 1'b1;
  endfunction

  // Entered in frame cycle 1 (the cycle after the handshake edge); checks
  // cycles 1..40 and returns positioned in cycle 41 after checking tx_done.
  task automatic frame1(input logic [7:0] d, input bit hold, input int inject_c, input string nm);
    for (int c = 1; c <= 40; c++) begin
      if (c == 1 && !hold) tx_valid = 1'b0;
      if (inject_c != 0 && c == inject_c) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (inject_c != 0 && c == inject_c + 1) tx_valid = 1'b0;
      check($sformatf("%s bit c%0d", nm, c), {7'b0, tx_bit}, {7'b0, exp_bit(d, c)});
      check($sformatf("%s sel c%0d", nm, c), {7'b0, tx_sel}, 8'h01);
      check($sformatf("%s done c%0d", nm, c), {7'b0, tx_done}, 8'h00);
      check($sformatf("%s ready c%0d", nm, c), {7'b0, tx_ready}, 8'h00);
      tick();
    end
    check({nm, " done c41"}, {7'b0, tx_done}, 8'h01);
    check({nm, " ready c41"}, {7'b0, tx_ready}, 8'h01);
    check({nm, " sel c41"}, {7'b0, tx_sel}, 8'h00);
    check({nm, " bit c41"}, {7'b0, tx_bit}, 8'h01);
  endtask

  initial begin
    rst_n     = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'hA5;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;

    // reset held with tx_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst ready %0d", i), {7'b0, tx_ready}, 8'h01);
      check($sformatf("rst sel %0d", i),   {7'b0, tx_sel},   8'h00);
      check($sformatf("rst bit %0d", i),   {7'b0, tx_bit},   8'h01);
      check($sformatf("rst done %0d", i),  {7'b0, tx_done},  8'h00);
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post rst sel", {7'b0, tx_sel}, 8'h00);
    check("post rst ready", {7'b0, tx_ready}, 8'h01);

    // single frame 0xA5: line reads 0,1,0,1,0,0,1,0,1,1 in 4-cycle runs
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    frame1(8'hA5, 1'b0, 0, "a5");
    tick();
    check("a5 done c42", {7'b0, tx_done}, 8'h00);
    check("a5 sel c42", {7'b0, tx_sel}, 8'h00);

    // busy ignore: 0x00 frame, valid pulse with 0xFF at cycle 10
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    frame1(8'h00, 1'b0, 10, "busy");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("busy idle done %0d", i), {7'b0, tx_done}, 8'h00);
      check($sformatf("busy idle sel %0d", i), {7'b0, tx_sel}, 8'h00);
    end

    // back-to-back 0x55 then 0x3C with tx_valid held
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    tick();
    tx_data  = 8'h3C;
    frame1(8'h55, 1'b1, 0, "b2b1");
    tick();
    frame1(8'h3C, 1'b0, 0, "b2b2");
    tick();
    check("b2b end done", {7'b0, tx_done}, 8'h00);
    check("b2b end sel", {7'b0, tx_sel}, 8'h00);

    // reset at cycle 20 of a 0xFF frame
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("abort bit c%0d", c), {7'b0, tx_bit}, {7'b0, exp_bit(8'hFF, c)});
      check($sformatf("abort sel c%0d", c), {7'b0, tx_sel}, 8'h01);
      if (c == 20) rst_n = 1'b0;
      tick();
    end
    check("abort sel", {7'b0, tx_sel}, 8'h00);
    check("abort ready", {7'b0, tx_ready}, 8'h01);
    check("abort bit", {7'b0, tx_bit}, 8'h01);
    check("abort done", {7'b0, tx_done}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("abort quiet done %0d", i), {7'b0, tx_done}, 8'h00);
      check($sformatf("abort quiet sel %0d", i), {7'b0, tx_sel}, 8'h00);
    end
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    tick();
    frame1(8'h81, 1'b0, 0, "x81");

    // two stop bits: 0x01, stop high 8 cycles, tx_done in cycle 45
    tx_valid2 = 1'b1;
    tx_data2  = 8'h01;
    tick();
    tx_valid2 = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      check($sformatf("sb2 bit c%0d", c), {7'b0, tx_bit2}, {7'b0, exp_bit(8'h01, c)});
      check($sformatf("sb2 sel c%0d", c), {7'b0, tx_sel2}, 8'h01);
      check($sformatf("sb2 done c%0d", c), {7'b0, tx_done2}, 8'h00);
      tick();
    end
    check("sb2 done c45", {7'b0, tx_done2}, 8'h01);
    check("sb2 ready c45", {7'b0, tx_ready2}, 8'h01);
    check("sb2 sel c45", {7'b0, tx_sel2}, 8'h00);
    tick();
    check("sb2 done c46", {7'b0, tx_done2}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
